// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (prefetch, load/store), one-slave memory arbiter.
// Grants one transaction at a time. Data wins when it requests alone.
// When both masters request at once, the grant alternates using last_data.
// Acks are combinational pass-throughs, qualified by the current grant.
// Ports:
//   clk, reset            - clock and async active-high reset
//   instr_m_*             - instruction (prefetch) master: addr, access in; data_in, ack out
//   data_m_*              - data (load/store) master: addr, data_out, access, wr_en,
//                           bytesel in; data_in, ack out
//   q_m_*                 - merged memory port: addr, data_out, access, wr_en, bytesel
//                           out; data_in, ack in
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,

  input  logic [19:1] instr_m_addr,
  output logic [15:0] instr_m_data_in,
  input  logic        instr_m_access,
  output logic        instr_m_ack,

  input  logic [19:1] data_m_addr,
  output logic [15:0] data_m_data_in,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,

  output logic [19:1] q_m_addr,
  input  logic [15:0] q_m_data_in,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] GRANT_INSTR = 2'd1;
  localparam logic [1:0] GRANT_DATA  = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last_data;
  logic       last_data_next;

  always_comb begin
    state_next     = state;
    last_data_next = last_data;
    case (state)
      IDLE: begin
        if (instr_m_access && data_m_access)
          state_next = last_data ? GRANT_INSTR : GRANT_DATA;
        else if (data_m_access)
          state_next = GRANT_DATA;
        else if (instr_m_access)
          state_next = GRANT_INSTR;
      end
      GRANT_INSTR: begin
        // An ack in the same cycle as an abort still counts as completion.
        if (q_m_ack) begin
          state_next     = IDLE;
          last_data_next = 1'b0;
        end else if (!instr_m_access) begin
          state_next = IDLE;
        end
      end
      GRANT_DATA: begin
        if (q_m_ack) begin
          state_next     = IDLE;
          last_data_next = 1'b1;
        end else if (!data_m_access) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_data <= 1'b0;
    end else begin
      state     <= state_next;
      last_data <= last_data_next;
    end
  end

  always_comb begin
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_access   = 1'b0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    case (state)
      GRANT_INSTR: begin
        q_m_addr    = instr_m_addr;
        q_m_access  = instr_m_access;
        q_m_bytesel = 2'b11;
      end
      GRANT_DATA: begin
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_access   = data_m_access;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
      end
      default: ;
    endcase
  end

  assign instr_m_ack     = q_m_ack && (state == GRANT_INSTR);
  assign data_m_ack      = q_m_ack && (state == GRANT_DATA);
  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave memory arbiter that sits directly downstream of the core's instruction bus (prefetch) and data bus (load/store). It merges both onto a single 16-bit, 19-bit-word-addressed memory port toward the system memory and routes acks and read data back to the requesting master. It arbitrates one transaction at a time, gives data accesses priority, and alternates under contention so neither master starves.

## Interface
- No parameters.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_m_addr  in  19  instruction word address [19:1].
- instr_m_data_in  out  16  read data to prefetch.
- instr_m_access  in  1  instruction request; held high until acked.
- instr_m_ack  out  1  one-cycle completion strobe to prefetch.
- data_m_addr  in  19  data word address [19:1].
- data_m_data_in  out  16  read data to load/store.
- data_m_data_out  in  16  write data from load/store.
- data_m_access  in  1  data request; held high until acked.
- data_m_ack  out  1  one-cycle completion strobe to load/store.
- data_m_wr_en  in  1  1 = write, 0 = read.
- data_m_bytesel  in  2  byte lanes {hi, lo}.
- q_m_addr  out  19  merged address.
- q_m_data_in  in  16  read data from memory.
- q_m_data_out  out  16  write data to memory.
- q_m_access  out  1  merged request.
- q_m_ack  in  1  memory completion strobe.
- q_m_wr_en  out  1  merged write enable.
- q_m_bytesel  out  2  merged byte lanes.

## Operation
- States: IDLE, GRANT_INSTR, GRANT_DATA. Extra register last_data (1 = last completed grant was data).
- IDLE: both requests low -> stay. Only data -> GRANT_DATA. Only instr -> GRANT_INSTR. Both -> GRANT_INSTR if last_data = 1, else GRANT_DATA.
- GRANT_x: q_m_* driven from master x (combinational mux on state); q_m_access = x_access.
- GRANT_x with q_m_ack = 1 -> IDLE; last_data <= (x == data).
- GRANT_x with x_access = 0 and q_m_ack = 0 (abort) -> IDLE; last_data unchanged.
- instr_m_ack = q_m_ack & GRANT_INSTR; data_m_ack = q_m_ack & GRANT_DATA. Never both high.
- instr_m_data_in = data_m_data_in = q_m_data_in (broadcast; qualified by ack).
- Instruction grant: q_m_wr_en = 0, q_m_bytesel = 2'b11, q_m_data_out = 16'h0000.
- Data grant: q_m_wr_en, q_m_bytesel, q_m_data_out, q_m_addr passed from data port.
- IDLE: q_m_access = 0, q_m_wr_en = 0, q_m_bytesel = 2'b00, q_m_addr = 0, q_m_data_out = 0.
- Addresses are word addresses; no translation, no wrap handling (passed through unchanged).

## Timing
- Reset (async assert, sync release): state = IDLE, last_data = 0; every q_m_* output 0, both acks 0. Reset mid-transaction drops q_m_access the same cycle; in-flight q_m_ack after reset is ignored.
- Request sampled in IDLE at cycle N -> q_m_access high from cycle N+1.
- Ack is combinational pass-through: q_m_ack at cycle M -> master ack at cycle M; state IDLE at M+1.
- Minimum back-to-back spacing: one IDLE cycle between transactions; a master keeping access high after its ack is re-granted at M+2 (if it wins arbitration).
- q_m_ack in IDLE ignored (no master ack).
- q_m_ack in the same cycle as an abort is treated as completion.
- Request arriving for the non-granted master waits; held request is never lost.

## Test plan
- Reset: assert reset with data granted -> q_m_access=0, acks=0 same cycle; after release, both requests high -> data granted first (last_data=0).
- Single instr read: instr_m_addr=19'h12345, access high; memory acks after 3 cycles with 16'hBEEF -> q_m_addr=19'h12345, wr_en=0, bytesel=11, instr_m_ack one cycle with instr_m_data_in=16'hBEEF, data_m_ack=0.
- Single data byte write: addr 19'h00400, data 16'h00A5, bytesel=01, wr_en=1 -> q_m_* match exactly, data_m_ack on q_m_ack, IDLE next cycle.
- Contention: both held continuously for 4 transactions -> grant order data, instr, data, instr; each separated by one IDLE cycle.
- Abort: grant instr, drop instr_m_access before ack -> IDLE next cycle, q_m_access=0, no ack; pending data then granted.
- Stray ack: q_m_ack pulsed in IDLE -> no master ack, state remains IDLE.
